// File: rtl/ifetch_bp.sv
// Instruction fetch stage: PC register, instruction memory request, BTB-based
// next-PC prediction with 2-bit counters, and the IF/ID pipeline register.
module ifetch_bp #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BTB_IDX_W = 4,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ide_wait,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  input  logic        flush_valid,
  input  logic [31:0] flush_pc,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic [31:0] upd_target,
  input  logic        upd_taken,
  output logic [31:0] instr,
  output logic [31:0] pc_if2id,
  output logic [4:0]  wr_addr,
  output logic [6:0]  opcode,
  output logic        pred_taken_if2id,
  output logic [31:0] pred_target_if2id,
  output logic        valid_if2id
);

  localparam int BTB_ENTRIES = 1 << BTB_IDX_W;
  localparam int TAG_W       = 32 - BTB_IDX_W - 2;

  logic [31:0]          r_pc;
  logic                 r_btb_valid [BTB_ENTRIES];
  logic [TAG_W-1:0]     r_btb_tag   [BTB_ENTRIES];
  logic [31:0]          r_btb_tgt   [BTB_ENTRIES];
  logic [1:0]           r_btb_cnt   [BTB_ENTRIES];

  logic [BTB_IDX_W-1:0] w_idx;
  logic [TAG_W-1:0]     w_tag;
  logic                 w_hit;
  logic                 w_pred_taken;
  logic [31:0]          w_pc_plus4;
  logic [31:0]          w_next_pc;

  logic [BTB_IDX_W-1:0] w_upd_idx;
  logic [TAG_W-1:0]     w_upd_tag;
  logic                 w_upd_hit;

  assign imem_addr = r_pc;

  // Lookup is purely combinational on the current PC; it sees pre-update contents.
  always_comb begin
    w_idx        = r_pc[BTB_IDX_W+1:2];
    w_tag        = r_pc[31:BTB_IDX_W+2];
    w_hit        = r_btb_valid[w_idx] && (r_btb_tag[w_idx] == w_tag);
    w_pred_taken = w_hit && r_btb_cnt[w_idx][1];
    w_pc_plus4   = r_pc + 32'd4;
    if (w_pred_taken) begin
      w_next_pc = r_btb_tgt[w_idx];
    end else begin
      w_next_pc = w_pc_plus4;
    end
    w_upd_idx = upd_pc[BTB_IDX_W+1:2];
    w_upd_tag = upd_pc[31:BTB_IDX_W+2];
    w_upd_hit = r_btb_valid[w_upd_idx] && (r_btb_tag[w_upd_idx] == w_upd_tag);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc <= RESET_PC;
    end else if (flush_valid) begin
      r_pc <= flush_pc;
    end else if (!ide_wait && imem_ready) begin
      r_pc <= w_next_pc;
    end
  end

  // IF/ID register: flush beats stall; a memory wait inserts a bubble tagged with the held PC.
  always_ff @(posedge clk) begin
    if (rst) begin
      instr             <= NOP_INSTR;
      pc_if2id          <= 32'h0000_0000;
      wr_addr           <= 5'd0;
      opcode            <= 7'h13;
      pred_taken_if2id  <= 1'b0;
      pred_target_if2id <= 32'h0000_0000;
      valid_if2id       <= 1'b0;
    end else if (flush_valid) begin
      instr             <= NOP_INSTR;
      pc_if2id          <= flush_pc;
      wr_addr           <= 5'd0;
      opcode            <= 7'h13;
      pred_taken_if2id  <= 1'b0;
      pred_target_if2id <= 32'h0000_0000;
      valid_if2id       <= 1'b0;
    end else if (!ide_wait) begin
      if (imem_ready) begin
        instr             <= imem_rdata;
        pc_if2id          <= r_pc;
        wr_addr           <= imem_rdata[11:7];
        opcode            <= imem_rdata[6:0];
        pred_taken_if2id  <= w_pred_taken;
        pred_target_if2id <= w_next_pc;
        valid_if2id       <= 1'b1;
      end else begin
        instr             <= NOP_INSTR;
        pc_if2id          <= r_pc;
        wr_addr           <= 5'd0;
        opcode            <= 7'h13;
        pred_taken_if2id  <= 1'b0;
        pred_target_if2id <= 32'h0000_0000;
        valid_if2id       <= 1'b0;
      end
    end
  end

  // BTB training runs regardless of flush/stall; a taken miss overwrites the aliased entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        r_btb_valid[i] <= 1'b0;
        r_btb_tag[i]   <= '0;
        r_btb_tgt[i]   <= 32'h0000_0000;
        r_btb_cnt[i]   <= 2'b01;
      end
    end else if (upd_valid) begin
      if (w_upd_hit) begin
        if (upd_taken) begin
          r_btb_tgt[w_upd_idx] <= upd_target;
          if (r_btb_cnt[w_upd_idx] != 2'b11) begin
            r_btb_cnt[w_upd_idx] <= r_btb_cnt[w_upd_idx] + 2'b01;
          end
        end else if (r_btb_cnt[w_upd_idx] != 2'b00) begin
          r_btb_cnt[w_upd_idx] <= r_btb_cnt[w_upd_idx] - 2'b01;
        end
      end else if (upd_taken) begin
        r_btb_valid[w_upd_idx] <= 1'b1;
        r_btb_tag[w_upd_idx]   <= w_upd_tag;
        r_btb_tgt[w_upd_idx]   <= upd_target;
        r_btb_cnt[w_upd_idx]   <= 2'b10;
      end
    end
  end

endmodule

// File: tb/tb_ifetch_bp.sv
// Directed testbench for ifetch_bp; memory model returns {addr[15:0], 16'h02B3}.
module tb_ifetch_bp;

  logic        clk = 1'b0;
  logic        rst;
  logic        ide_wait;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic        flush_valid;
  logic [31:0] flush_pc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [31:0] upd_target;
  logic        upd_taken;
  logic [31:0] instr;
  logic [31:0] pc_if2id;
  logic [4:0]  wr_addr;
  logic [6:0]  opcode;
  logic        pred_taken_if2id;
  logic [31:0] pred_target_if2id;
  logic        valid_if2id;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  assign imem_rdata = {imem_addr[15:0], 16'h02B3};

  ifetch_bp dut (
    .clk(clk), .rst(rst), .ide_wait(ide_wait),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ready(imem_ready),
    .flush_valid(flush_valid), .flush_pc(flush_pc),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target), .upd_taken(upd_taken),
    .instr(instr), .pc_if2id(pc_if2id), .wr_addr(wr_addr), .opcode(opcode),
    .pred_taken_if2id(pred_taken_if2id), .pred_target_if2id(pred_target_if2id),
    .valid_if2id(valid_if2id)
  );

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; ide_wait = 1'b0; imem_ready = 1'b1;
    flush_valid = 1'b0; flush_pc = 32'h0;
    upd_valid = 1'b0; upd_pc = 32'h0; upd_target = 32'h0; upd_taken = 1'b0;
    @(negedge clk);
    step();
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_instr", instr, 32'h0000_0013);
    chk("rst_pc", pc_if2id, 32'h0);
    chk("rst_rd", {27'd0, wr_addr}, 32'd0);
    chk("rst_op", {25'd0, opcode}, 32'h13);
    chk("rst_pt", {31'd0, pred_taken_if2id}, 32'd0);
    chk("rst_ptgt", pred_target_if2id, 32'h0);
    chk("rst_valid", {31'd0, valid_if2id}, 32'd0);

    // Sequential fetch 0,4,8
    rst = 1'b0;
    step();
    chk("seq_addr4", imem_addr, 32'h4);
    chk("seq_pc0", pc_if2id, 32'h0);
    chk("seq_instr0", instr, 32'h0000_02B3);
    chk("seq_valid0", {31'd0, valid_if2id}, 32'd1);
    chk("seq_rd0", {27'd0, wr_addr}, 32'd5);
    chk("seq_op0", {25'd0, opcode}, 32'h33);
    chk("seq_ptgt0", pred_target_if2id, 32'h4);
    step();
    chk("seq_addr8", imem_addr, 32'h8);
    chk("seq_pc4", pc_if2id, 32'h4);

    // Stall 3 cycles at pc=8
    ide_wait = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_addr", imem_addr, 32'h8);
      chk("stall_pc", pc_if2id, 32'h4);
      chk("stall_instr", instr, 32'h0004_02B3);
    end
    ide_wait = 1'b0;
    step();
    chk("rel_pc8", pc_if2id, 32'h8);
    chk("rel_addrC", imem_addr, 32'hC);

    // Memory wait 2 cycles at pc=C
    imem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("mw_valid", {31'd0, valid_if2id}, 32'd0);
      chk("mw_pc", pc_if2id, 32'hC);
      chk("mw_instr", instr, 32'h0000_0013);
      chk("mw_addr", imem_addr, 32'hC);
    end
    imem_ready = 1'b1;
    step();
    chk("mw_done_pc", pc_if2id, 32'hC);
    chk("mw_done_instr", instr, 32'h000C_02B3);
    chk("mw_done_valid", {31'd0, valid_if2id}, 32'd1);
    chk("mw_done_addr", imem_addr, 32'h10);

    // Flush concurrent with stall
    flush_valid = 1'b1; flush_pc = 32'h100; ide_wait = 1'b1;
    step();
    chk("fl_addr", imem_addr, 32'h100);
    chk("fl_valid", {31'd0, valid_if2id}, 32'd0);
    chk("fl_instr", instr, 32'h0000_0013);
    chk("fl_pc", pc_if2id, 32'h100);
    flush_valid = 1'b0; ide_wait = 1'b0;
    step();
    chk("fl_next_pc", pc_if2id, 32'h100);
    chk("fl_next_instr", instr, 32'h0100_02B3);
    chk("fl_next_addr", imem_addr, 32'h104);

    // Allocate BTB entry for 0x20 -> 0x80, flush to 0x20 in the same cycle
    upd_valid = 1'b1; upd_pc = 32'h20; upd_target = 32'h80; upd_taken = 1'b1;
    flush_valid = 1'b1; flush_pc = 32'h20;
    step();
    upd_valid = 1'b0; flush_valid = 1'b0;
    chk("btb_pc20", imem_addr, 32'h20);
    step();
    chk("btb_hit_pc", pc_if2id, 32'h20);
    chk("btb_hit_pt", {31'd0, pred_taken_if2id}, 32'd1);
    chk("btb_hit_ptgt", pred_target_if2id, 32'h80);
    chk("btb_hit_addr", imem_addr, 32'h80);

    // Two not-taken updates during a stall: 10 -> 01 -> 00
    ide_wait = 1'b1; upd_valid = 1'b1; upd_taken = 1'b0;
    step();
    step();
    upd_valid = 1'b0; ide_wait = 1'b0;
    flush_valid = 1'b1; flush_pc = 32'h20;
    step();
    flush_valid = 1'b0;
    step();
    chk("nt_pc", pc_if2id, 32'h20);
    chk("nt_pt", {31'd0, pred_taken_if2id}, 32'd0);
    chk("nt_ptgt", pred_target_if2id, 32'h24);
    chk("nt_addr", imem_addr, 32'h24);

    // Retrain 0x20 taken twice (00 -> 01 -> 10), then confirm it predicts again
    ide_wait = 1'b1; upd_valid = 1'b1; upd_taken = 1'b1; upd_pc = 32'h20; upd_target = 32'h80;
    step();
    step();
    upd_valid = 1'b0; ide_wait = 1'b0;
    flush_valid = 1'b1; flush_pc = 32'h20;
    step();
    flush_valid = 1'b0;
    step();
    chk("rt_pt", {31'd0, pred_taken_if2id}, 32'd1);
    chk("rt_addr", imem_addr, 32'h80);

    // Alias: 0x60 shares index 8, allocation evicts 0x20
    ide_wait = 1'b1; upd_valid = 1'b1; upd_taken = 1'b1; upd_pc = 32'h60; upd_target = 32'h200;
    step();
    upd_valid = 1'b0; ide_wait = 1'b0;
    flush_valid = 1'b1; flush_pc = 32'h20;
    step();
    flush_valid = 1'b0;
    step();
    chk("al_pt20", {31'd0, pred_taken_if2id}, 32'd0);
    chk("al_ptgt20", pred_target_if2id, 32'h24);
    chk("al_addr24", imem_addr, 32'h24);
    flush_valid = 1'b1; flush_pc = 32'h60;
    step();
    flush_valid = 1'b0;
    step();
    chk("al_pt60", {31'd0, pred_taken_if2id}, 32'd1);
    chk("al_addr200", imem_addr, 32'h200);

    // Reset beats flush and clears the BTB
    rst = 1'b1; flush_valid = 1'b1; flush_pc = 32'h300;
    step();
    chk("rr_addr", imem_addr, 32'h0);
    chk("rr_valid", {31'd0, valid_if2id}, 32'd0);
    rst = 1'b0; flush_pc = 32'h60;
    step();
    flush_valid = 1'b0;
    step();
    chk("rr_btb_pt", {31'd0, pred_taken_if2id}, 32'd0);
    chk("rr_btb_addr", imem_addr, 32'h64);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
